snoop_bus_arbiter: RTL and testbench

//  Parametrised snooping-bus controller for the MSI cache array.
//  - Arbitrates NUM_PROCS cache request lines with fair round-robin.
//  - Broadcasts the winner's message and address to all snoopers for one cycle.
//  - Sources the line from a snooper flush or from memory, writes flushed lines back to memory, and returns the data to the requester.
//  - Holds the grant for the whole multi-cycle transaction.

---
 rtl/snoop_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus controller: round-robin arbitration, one-cycle snoop broadcast,
// line sourcing from a flushing snooper or memory, and return to the requester.
module snoop_bus_arbiter #(
    parameter int NUM_PROCS   = 4,
    parameter int ADDR_SIZE   = 32,
    parameter int LINE_SIZE   = 128,
    parameter int MEM_TIMEOUT = 255,
    localparam int OWN_W      = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PROCS-1:0]           req_i,
    input  logic [2*NUM_PROCS-1:0]         msg_i,
    input  logic [ADDR_SIZE*NUM_PROCS-1:0] addr_i,
    input  logic [NUM_PROCS-1:0]           flush_i,
    input  logic [LINE_SIZE*NUM_PROCS-1:0] flush_data_i,
    output logic [NUM_PROCS-1:0]           gnt_o,
    output logic                           bus_valid_o,
    output logic [1:0]                     bus_msg_o,
    output logic [ADDR_SIZE-1:0]           bus_addr_o,
    output logic [OWN_W-1:0]               bus_owner_o,
    output logic [LINE_SIZE-1:0]           data_o,
    output logic                           data_valid_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_SIZE-1:0]           mem_addr_o,
    output logic [LINE_SIZE-1:0]           mem_wdata_o,
    input  logic [LINE_SIZE-1:0]           mem_rdata_i,
    input  logic                           mem_ack_i,
    output logic [1:0]                     state_o
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [1:0] BUS_UPGR = 2'b10;
    localparam logic [1:0] BUS_WB   = 2'b11;

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, RESP} state_t;

    state_t                 state_q, state_d;
    logic [OWN_W-1:0]       rr_q, rr_d;
    logic [OWN_W-1:0]       owner_q, owner_d;
    logic [1:0]             msg_q, msg_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic [LINE_SIZE-1:0]   line_q, line_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err;

    logic                   win_found;
    int                     win_idx;
    int                     owner_idx;
    int                     snoop_idx;
    int                     snoop_cnt;

    // Round-robin winner: first requester at or after rr_q, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            if (!win_found && req_i[(int'(rr_q) + i) % NUM_PROCS]) begin
                win_found = 1'b1;
                win_idx   = (int'(rr_q) + i) % NUM_PROCS;
            end
        end
    end

    // Non-owner flushers: the lowest index supplies the line, extras are an error.
    always_comb begin
        owner_idx = int'(owner_q);
        snoop_idx = 0;
        snoop_cnt = 0;
        for (int i = 0; i < NUM_PROCS; i++) begin
            if (flush_i[i] && i != owner_idx) begin
                if (snoop_cnt == 0) snoop_idx = i;
                snoop_cnt = snoop_cnt + 1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        msg_d   = msg_q;
        addr_d  = addr_q;
        we_d    = we_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d = OWN_W'(win_idx);
                    msg_d   = msg_i[2*win_idx +: 2];
                    addr_d  = addr_i[ADDR_SIZE*win_idx +: ADDR_SIZE];
                    state_d = SNOOP;
                end
            end
            SNOOP: begin
                we_d  = 1'b0;
                cnt_d = '0;
                if (msg_q == BUS_UPGR) begin
                    state_d = RESP;
                end else if (msg_q == BUS_WB) begin
                    if (flush_i[owner_idx]) begin
                        line_d  = flush_data_i[LINE_SIZE*owner_idx +: LINE_SIZE];
                        we_d    = 1'b1;
                        state_d = MEM;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    if (snoop_cnt > 0) begin
                        line_d = flush_data_i[LINE_SIZE*snoop_idx +: LINE_SIZE];
                        we_d   = 1'b1;
                        err    = (snoop_cnt > 1);
                    end else begin
                        line_d = '0;
                    end
                    state_d = MEM;
                end
            end
            MEM: begin
                if (mem_ack_i) begin
                    if (!we_q) line_d = mem_rdata_i;
                    cnt_d   = '0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    err     = 1'b1;
                    line_d  = '0;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                rr_d    = (owner_q == OWN_W'(NUM_PROCS - 1)) ? '0 : owner_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            msg_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            msg_q   <= msg_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything except the grant and owner index is gated by its state.
    assign gnt_o        = (state_q != IDLE) ? (NUM_PROCS'(1) << owner_q) : '0;
    assign bus_valid_o  = (state_q == SNOOP);
    assign bus_msg_o    = (state_q == SNOOP) ? msg_q : '0;
    assign bus_addr_o   = (state_q == SNOOP) ? addr_q : '0;
    assign bus_owner_o  = owner_q;
    assign data_valid_o = (state_q == RESP) && !msg_q[1];
    assign data_o       = data_valid_o ? line_q : '0;
    assign done_o       = (state_q == RESP);
    assign err_o        = err;
    assign mem_req_o    = (state_q == MEM);
    assign mem_we_o     = (state_q == MEM) && we_q;
    assign mem_addr_o   = (state_q == MEM) ? addr_q : '0;
    assign mem_wdata_o  = ((state_q == MEM) && we_q) ? line_q : '0;
    assign state_o      = state_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the bus rules.
module tb_snoop_bus_arbiter;

    localparam int N     = 4;
    localparam int AW    = 32;
    localparam int LW    = 128;
    localparam int MEM_T = 12;

    // Valid/ready note: req_i is held by a cache until its done_o pulse; mem_ack_i
    // completes the mem_req_o access in the same cycle it is sampled high.

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic [N-1:0]      req_i;
    logic [2*N-1:0]    msg_i;
    logic [AW*N-1:0]   addr_i;
    logic [N-1:0]      flush_i;
    logic [LW*N-1:0]   flush_data_i;
    logic [N-1:0]      gnt_o;
    logic              bus_valid_o;
    logic [1:0]        bus_msg_o;
    logic [AW-1:0]     bus_addr_o;
    logic [1:0]        bus_owner_o;
    logic [LW-1:0]     data_o;
    logic              data_valid_o;
    logic              done_o;
    logic              err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [LW-1:0]     mem_wdata_o;
    logic [LW-1:0]     mem_rdata_i;
    logic              mem_ack_i;
    logic [1:0]        state_o;

    snoop_bus_arbiter #(
        .NUM_PROCS(N), .ADDR_SIZE(AW), .LINE_SIZE(LW), .MEM_TIMEOUT(MEM_T)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .msg_i(msg_i), .addr_i(addr_i),
        .flush_i(flush_i), .flush_data_i(flush_data_i), .gnt_o(gnt_o),
        .bus_valid_o(bus_valid_o), .bus_msg_o(bus_msg_o), .bus_addr_o(bus_addr_o),
        .bus_owner_o(bus_owner_o), .data_o(data_o), .data_valid_o(data_valid_o),
        .done_o(done_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .state_o(state_o)
    );

    // ---------------- scoreboard state ----------------
    int chk_cnt = 0;
    int err_cnt = 0;
    int rr_model = 0;
    logic [1:0] exp_q[$];

    typedef struct {
        logic [3:0]   gnt;
        logic [1:0]   owner;
        bit           gnt_ok;
        int           snoop_n;
        logic [1:0]   bmsg;
        logic [31:0]  baddr;
        int           mem_n;
        logic         mem_we;
        logic [31:0]  maddr;
        logic [127:0] mwdata;
        bit           mem_ok;
        int           err_n;
        bit           stray_dv;
        bit           done;
        int           lat;
        logic         dv;
        logic [127:0] data;
    } obs_t;

    typedef struct {
        int           own;
        bit           we;
        logic [127:0] wdata;
        int           mem_n;
        int           lat;
        bit           dv;
        logic [127:0] data;
        int           err_n;
    } exp_t;

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [511:0] rand_fd();
        return {rand_line(), rand_line(), rand_line(), rand_line()};
    endfunction

    // ---------------- reference model ----------------
    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // ack_at: MEM cycle (1-based) on which memory acks; 0 means never.
    function automatic exp_t predict(input int own, input logic [1:0] m, input logic [3:0] fl,
                                     input logic [511:0] fd, input int ack_at,
                                     input logic [127:0] rd);
        exp_t e;
        bit   tmo;
        int   mn;
        logic [3:0] others;
        tmo    = (ack_at <= 0) || (ack_at > MEM_T);
        mn     = tmo ? MEM_T : ack_at;
        others = fl & ~(4'b0001 << own);
        e = '{own: own, we: 0, wdata: '0, mem_n: 0, lat: 2, dv: 0, data: '0, err_n: 0};
        if (m == 2'b11) begin
            if (fl[own]) begin
                e.we = 1; e.wdata = fd[128*own +: 128];
                e.mem_n = mn; e.lat = 2 + mn; e.err_n = tmo ? 1 : 0;
            end
        end else if (m != 2'b10) begin
            e.dv = 1; e.mem_n = mn; e.lat = 2 + mn; e.err_n = tmo ? 1 : 0;
            if (others != 0) begin
                for (int j = N - 1; j >= 0; j--) if (others[j]) e.wdata = fd[128*j +: 128];
                e.we   = 1;
                e.data = tmo ? '0 : e.wdata;
                if ($countones(others) > 1) e.err_n++;
            end else begin
                e.data = tmo ? '0 : rd;
            end
        end
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        rst_i = 1'b0;
        req_i = '0; flush_i = '0; mem_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        rr_model = 0;
    endtask

    // Drives one transaction until done_o (bounded) and records what the bus did.
    task automatic run_txn(input logic [3:0] r, input logic [7:0] m, input logic [127:0] a,
                           input logic [511:0] fd, input logic [3:0] fl, input int ack_at,
                           input logic [127:0] rd, output obs_t o);
        int g;
        int mk;
        g  = -1;
        mk = 0;
        o  = '{default: 0};
        o.gnt_ok = 1; o.mem_ok = 1;
        req_i = r; msg_i = m; addr_i = a; flush_data_i = fd;
        for (int c = 0; c < MEM_T + 30 && !o.done; c++) begin
            @(negedge clk);
            flush_i     = bus_valid_o ? fl : 4'b0000;
            mem_ack_i   = 1'b0;
            mem_rdata_i = rand_line();
            if (mem_req_o) begin
                mk++;
                if (mk == ack_at) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rd;
                end
            end
            #1;
            if (g < 0) begin
                if (gnt_o != 0) begin
                    g = c; o.gnt = gnt_o; o.owner = bus_owner_o;
                end
            end else if (gnt_o !== o.gnt) begin
                o.gnt_ok = 0;
            end
            if (bus_valid_o) begin
                o.snoop_n++; o.bmsg = bus_msg_o; o.baddr = bus_addr_o;
            end
            if (mem_req_o) begin
                if (o.mem_n == 0) begin
                    o.mem_we = mem_we_o; o.maddr = mem_addr_o; o.mwdata = mem_wdata_o;
                end else if (mem_we_o !== o.mem_we || mem_addr_o !== o.maddr ||
                             mem_wdata_o !== o.mwdata) begin
                    o.mem_ok = 0;
                end
                o.mem_n++;
            end
            if (err_o) o.err_n++;
            if (data_valid_o && !done_o) o.stray_dv = 1;
            if (done_o) begin
                o.done = 1; o.lat = c - g + 1; o.dv = data_valid_o; o.data = data_o;
            end
        end
        flush_i   = '0;
        mem_ack_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        req_i = 4'b1111; msg_i = 8'($urandom); addr_i = rand_line(); flush_i = 4'b1111;
        flush_data_i = rand_fd(); mem_ack_i = 1'b1; mem_rdata_i = rand_line();
        repeat (3) @(negedge clk);
        #1;
        chk_cnt++;
        if ({gnt_o, bus_valid_o, bus_msg_o, bus_addr_o, bus_owner_o} !== '0) begin
            err_cnt++; $display("FAIL reset_bus: got gnt=%b valid=%b owner=%0d want all 0",
                                gnt_o, bus_valid_o, bus_owner_o);
        end
        chk_cnt++;
        if ({data_o, data_valid_o, done_o, err_o} !== '0) begin
            err_cnt++; $display("FAIL reset_resp: got dv=%b done=%b err=%b want 0",
                                data_valid_o, done_o, err_o);
        end
        chk_cnt++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin
            err_cnt++; $display("FAIL reset_mem: got req=%b we=%b want 0", mem_req_o, mem_we_o);
        end
        apply_reset();
    endtask

    task automatic test_basic_read();
        obs_t o;
        run_txn(4'b0001, {6'($urandom), 2'b00}, {96'($urandom), 32'h40}, rand_fd(), 4'b0000,
                3, 128'hCAFE, o);
        chk_cnt++; if (o.gnt !== 4'b0001) begin err_cnt++; $display("FAIL rd_gnt: got %b want 0001", o.gnt); end
        chk_cnt++; if (o.snoop_n != 1) begin err_cnt++; $display("FAIL rd_snoop_cycles: got %0d want 1", o.snoop_n); end
        chk_cnt++; if (o.baddr !== 32'h40 || o.bmsg !== 2'b00) begin err_cnt++; $display("FAIL rd_bcast: got %h/%b want 40/00", o.baddr, o.bmsg); end
        chk_cnt++; if (o.mem_we !== 1'b0 || o.maddr !== 32'h40) begin err_cnt++; $display("FAIL rd_mem: got we=%b addr=%h want 0/40", o.mem_we, o.maddr); end
        chk_cnt++; if (!o.done || o.lat != 5) begin err_cnt++; $display("FAIL rd_latency: got %0d want 5", o.lat); end
        chk_cnt++; if (o.dv !== 1'b1 || o.data !== 128'hCAFE) begin err_cnt++; $display("FAIL rd_data: got dv=%b %h want 1 cafe", o.dv, o.data); end
        rr_model = 1;
    endtask

    task automatic test_round_robin();
        obs_t o;
        logic [1:0] want;
        apply_reset();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        for (int t = 0; t < 5; t++) begin
            run_txn(4'b1111, 8'b10101010, rand_line(), rand_fd(), 4'($urandom), 0, rand_line(), o);
            want = exp_q.pop_front();
            chk_cnt++; if (o.gnt !== (4'b0001 << want)) begin err_cnt++; $display("FAIL rr_gnt[%0d]: got %b want %b", t, o.gnt, 4'b0001 << want); end
            chk_cnt++; if (!o.done || o.lat != 2) begin err_cnt++; $display("FAIL rr_upgr_latency[%0d]: got %0d want 2", t, o.lat); end
        end
        rr_model = 1;
    endtask

    task automatic test_flush_forward();
        obs_t o;
        logic [511:0] fd;
        fd = rand_fd();
        fd[128*1 +: 128] = 128'hDEAD;
        run_txn(4'b0100, {2'($urandom), 2'b01, 4'($urandom)}, {rand_line()} & ~(128'hFFFFFFFF << 64) | (128'h80 << 64),
                fd, 4'b0010, 1, rand_line(), o);
        chk_cnt++; if (o.gnt !== 4'b0100) begin err_cnt++; $display("FAIL fwd_gnt: got %b want 0100", o.gnt); end
        chk_cnt++; if (o.mem_we !== 1'b1 || o.maddr !== 32'h80 || o.mwdata !== 128'hDEAD) begin err_cnt++; $display("FAIL fwd_wb: got we=%b %h %h want 1 80 dead", o.mem_we, o.maddr, o.mwdata); end
        chk_cnt++; if (o.dv !== 1'b1 || o.data !== 128'hDEAD || o.lat != 3) begin err_cnt++; $display("FAIL fwd_data: got dv=%b %h lat=%0d want 1 dead 3", o.dv, o.data, o.lat); end
        rr_model = 3;
    endtask

    task automatic test_upgrade();
        obs_t o;
        run_txn(4'b1000, {2'b10, 6'($urandom)}, rand_line(), rand_fd(), 4'b1111, 1, rand_line(), o);
        chk_cnt++; if (o.gnt !== 4'b1000) begin err_cnt++; $display("FAIL upgr_gnt: got %b want 1000", o.gnt); end
        chk_cnt++; if (!o.done || o.lat != 2 || o.mem_n != 0) begin err_cnt++; $display("FAIL upgr_flow: got lat=%0d memcyc=%0d want 2 0", o.lat, o.mem_n); end
        chk_cnt++; if (o.dv !== 1'b0 || o.err_n != 0) begin err_cnt++; $display("FAIL upgr_dv: got dv=%b err=%0d want 0 0", o.dv, o.err_n); end
        rr_model = 0;
    endtask

    task automatic test_multi_flush();
        obs_t o;
        logic [511:0] fd;
        logic [127:0] p1;
        fd = rand_fd();
        p1 = fd[128 +: 128];
        run_txn(4'b0001, {6'($urandom), 2'b00}, rand_line(), fd, 4'b0110, 2, rand_line(), o);
        chk_cnt++; if (o.err_n != 1) begin err_cnt++; $display("FAIL mflush_err: got %0d pulses want 1", o.err_n); end
        chk_cnt++; if (o.mwdata !== p1 || o.data !== p1 || o.dv !== 1'b1) begin err_cnt++; $display("FAIL mflush_data: got %h want %h", o.data, p1); end
        rr_model = 1;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(4'b0010, {4'($urandom), 2'b01, 2'($urandom)}, rand_line(), rand_fd(), 4'b0000,
                0, rand_line(), o);
        chk_cnt++; if (o.err_n != 1) begin err_cnt++; $display("FAIL tmo_err: got %0d pulses want 1", o.err_n); end
        chk_cnt++; if (o.mem_n != MEM_T || o.lat != MEM_T + 2) begin err_cnt++; $display("FAIL tmo_cycles: got mem=%0d lat=%0d want %0d %0d", o.mem_n, o.lat, MEM_T, MEM_T + 2); end
        chk_cnt++; if (o.dv !== 1'b1 || o.data !== '0) begin err_cnt++; $display("FAIL tmo_data: got dv=%b %h want 1 0", o.dv, o.data); end
        rr_model = 2;
    endtask

    task automatic test_writeback();
        obs_t o;
        logic [511:0] fd;
        fd = rand_fd();
        run_txn(4'b0001, {6'($urandom), 2'b11}, rand_line(), fd, 4'b0001, 2, rand_line(), o);
        chk_cnt++; if (o.mem_we !== 1'b1 || o.mwdata !== fd[127:0] || o.lat != 4) begin err_cnt++; $display("FAIL wb_write: got we=%b lat=%0d want 1 4", o.mem_we, o.lat); end
        chk_cnt++; if (o.dv !== 1'b0) begin err_cnt++; $display("FAIL wb_dv: got %b want 0", o.dv); end
        run_txn(4'b0010, {4'($urandom), 2'b11, 2'($urandom)}, rand_line(), fd, 4'b1101, 2, rand_line(), o);
        chk_cnt++; if (o.mem_n != 0 || o.lat != 2) begin err_cnt++; $display("FAIL wb_noflush: got mem=%0d lat=%0d want 0 2", o.mem_n, o.lat); end
        rr_model = 2;
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic [3:0]   r, fl;
        logic [7:0]   m;
        logic [127:0] a, rd;
        logic [511:0] fd;
        logic [1:0]   want;
        int           ack_at;
        for (int t = 0; t < 30; t++) begin
            r  = 4'($urandom_range(1, 15));
            m  = 8'($urandom);
            a  = rand_line();
            fd = rand_fd();
            fl = 4'($urandom);
            rd = rand_line();
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            e = predict(pick(r, rr_model), m[2*pick(r, rr_model) +: 2], fl, fd, ack_at, rd);
            exp_q.push_back(2'(e.own));
            run_txn(r, m, a, fd, fl, ack_at, rd, o);
            want = exp_q.pop_front();
            chk_cnt++; if (o.gnt !== (4'b0001 << want) || o.owner !== want) begin err_cnt++; $display("FAIL rnd_gnt[%0d]: got %b/%0d want owner %0d", t, o.gnt, o.owner, want); end
            chk_cnt++; if (o.snoop_n != 1 || o.bmsg !== m[2*e.own +: 2] || o.baddr !== a[32*e.own +: 32]) begin err_cnt++; $display("FAIL rnd_bcast[%0d]: got n=%0d %b %h", t, o.snoop_n, o.bmsg, o.baddr); end
            chk_cnt++; if (!o.done || o.lat != e.lat || o.mem_n != e.mem_n) begin err_cnt++; $display("FAIL rnd_timing[%0d]: got lat=%0d mem=%0d want %0d %0d", t, o.lat, o.mem_n, e.lat, e.mem_n); end
            if (e.mem_n > 0) begin
                chk_cnt++; if (o.mem_we !== e.we || o.maddr !== a[32*e.own +: 32] || !o.mem_ok) begin err_cnt++; $display("FAIL rnd_mem[%0d]: got we=%b %h stable=%0d want %b", t, o.mem_we, o.maddr, o.mem_ok, e.we); end
                chk_cnt++; if (o.mwdata !== (e.we ? e.wdata : '0)) begin err_cnt++; $display("FAIL rnd_wdata[%0d]: got %h want %h", t, o.mwdata, e.wdata); end
            end
            chk_cnt++; if (o.dv !== e.dv || o.data !== (e.dv ? e.data : '0) || o.stray_dv) begin err_cnt++; $display("FAIL rnd_data[%0d]: got dv=%b %h want %b %h", t, o.dv, o.data, e.dv, e.data); end
            chk_cnt++; if (o.err_n != e.err_n || !o.gnt_ok) begin err_cnt++; $display("FAIL rnd_err[%0d]: got %0d gnt_held=%0d want %0d", t, o.err_n, o.gnt_ok, e.err_n); end
            rr_model = (e.own + 1) % N;
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   in_mem;
        bit   done_seen;
        run_txn(4'b0100, 8'b10101010, rand_line(), rand_fd(), 4'b0000, 0, rand_line(), o);
        req_i = 4'b1000; msg_i = 8'b00101010; flush_i = '0; mem_ack_i = 1'b0;
        in_mem = 0; done_seen = 0;
        for (int c = 0; c < 10 && !in_mem; c++) begin
            @(negedge clk); #1;
            if (done_o) done_seen = 1;
            if (mem_req_o) in_mem = 1;
        end
        chk_cnt++; if (!in_mem || bus_owner_o !== 2'd3) begin err_cnt++; $display("FAIL rstmid_reach_mem: got mem=%0d owner=%0d want 1 3", in_mem, bus_owner_o); end
        rst_i = 1'b0;
        @(negedge clk); #1;
        if (done_o) done_seen = 1;
        chk_cnt++; if ({gnt_o, bus_valid_o, bus_owner_o, mem_req_o, mem_we_o, mem_addr_o, data_valid_o, done_o, err_o} !== '0) begin err_cnt++; $display("FAIL rstmid_outputs: got gnt=%b owner=%0d memreq=%b want 0", gnt_o, bus_owner_o, mem_req_o); end
        chk_cnt++; if (done_seen) begin err_cnt++; $display("FAIL rstmid_done: got done pulse want none"); end
        rst_i = 1'b1;
        rr_model = 0;
        run_txn(4'b1010, 8'($urandom) | 8'b10001000, rand_line(), rand_fd(), 4'b0000, 0, rand_line(), o);
        chk_cnt++; if (o.gnt !== 4'b0010) begin err_cnt++; $display("FAIL rstmid_rrptr: got %b want 0010", o.gnt); end
        run_txn(4'b0100, 8'b10101010, rand_line(), rand_fd(), 4'b0000, 0, rand_line(), o);
        chk_cnt++; if (o.gnt !== 4'b0100 || !o.done) begin err_cnt++; $display("FAIL rstmid_fresh: got %b want 0100", o.gnt); end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        rst_i = 1'b0; req_i = '0; msg_i = '0; addr_i = '0; flush_i = '0;
        flush_data_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;
        test_reset();
        test_basic_read();
        test_round_robin();
        test_flush_forward();
        test_upgrade();
        test_multi_flush();
        test_timeout();
        test_writeback();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
